mul_div_unit: RTL and testbench

//   Iterative multiply/divide unit for the MIPS datapath (MULT, MULTU, DIV, DIVU,

---
 rtl/mul_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module  : mul_div_unit
// Brief   : Iterative MIPS multiply/divide unit (shift-add / restoring, 1 bit per cycle)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [1:0] C_OP_MULT = 2'd0;
  localparam logic [1:0] C_OP_DIV  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               w_signed;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;

  // Magnitudes: the most negative value maps to itself, read as unsigned.
  assign w_signed = (op == C_OP_MULT) || (op == C_OP_DIV);
  assign w_a_neg  = w_signed && a[WIDTH-1];
  assign w_b_neg  = w_signed && b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  assign w_rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, opnd_q};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      a_orig_q  <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      a_orig_q  <= a_orig_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    a_orig_d  = a_orig_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          opnd_d    = op[1] ? w_b_mag : w_a_mag;
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
          a_orig_d  = a;
          neg_res_d = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          cnt_d     = '0;
          state_d   = S_CALC;
        end else begin
          if (hi_wr) hi_d = wdata;
          if (lo_wr) lo_d = wdata;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? w_div_next : w_mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (opnd_q == '0) begin
            hi_d  = a_orig_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end else begin
          {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, monitor pops expected HI/LO on done.
`default_nettype none

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_wr = 1'b0, lo_wr = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && div_by_zero && !done) chk("dbz_without_done", 32'(div_by_zero), 32'd0);
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Pulses start across one rising edge; returns at the first negedge after it.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input bit push);
    if (push) exp_q.push_back('{hi: eh, lo: el, dbz: ed});
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge until busy drops, then checks done timing.
  task automatic wait_done(input int exp_busy);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'(exp_busy));
    chk("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{op: 2'd1, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001, dbz: 1'b0};
    vecs[1] = '{op: 2'd0, a: 32'hFFFFFFFD, b: 32'h00000005, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1, dbz: 1'b0};
    vecs[2] = '{op: 2'd0, a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000, dbz: 1'b0};
    vecs[3] = '{op: 2'd1, a: 32'h00010000, b: 32'h00010000, hi: 32'h00000001, lo: 32'h00000000, dbz: 1'b0};
    vecs[4] = '{op: 2'd2, a: 32'hFFFFFFF9, b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dbz: 1'b0};
    vecs[5] = '{op: 2'd2, a: 32'h00000007, b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD, dbz: 1'b0};
    vecs[6] = '{op: 2'd3, a: 32'h00000064, b: 32'h00000007, hi: 32'h00000002, lo: 32'h0000000E, dbz: 1'b0};
    vecs[7] = '{op: 2'd2, a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000, dbz: 1'b0};
    vecs[8] = '{op: 2'd3, a: 32'hFFFFFFFF, b: 32'h00000010, hi: 32'h0000000F, lo: 32'h0FFFFFFF, dbz: 1'b0};
    vecs[9] = '{op: 2'd3, a: 32'h12345678, b: 32'h00000000, hi: 32'h12345678, lo: 32'hFFFFFFFF, dbz: 1'b1};

    // Reset state
    @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz, 1'b1);
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_done(33);
    end

    // Start and MTLO while busy are ignored; HI/LO hold old values meanwhile.
    issue(2'd1, 32'd3, 32'd4, 32'h0, 32'h0000000C, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6; lo_wr = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; lo_wr = 1'b0;
    chk("lo_stable_busy", lo, 32'hFFFFFFFF);
    chk("hi_stable_busy", hi, 32'h12345678);
    wait_done(23);

    // MTLO while idle
    lo_wr = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    lo_wr = 1'b0;
    chk("mtlo_lo", lo, 32'hDEADBEEF);
    chk("mtlo_hi_kept", hi, 32'h00000000);

    // MTHI and MTLO together
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    chk("both_hi", hi, 32'hA5A5A5A5);
    chk("both_lo", lo, 32'hA5A5A5A5);

    // Start coinciding with MTHI while idle: start wins
    hi_wr = 1'b1; wdata = 32'h11111111;
    issue(2'd1, 32'd7, 32'd9, 32'h0, 32'd63, 1'b0, 1'b1);
    hi_wr = 1'b0;
    chk("start_wins_hi", hi, 32'hA5A5A5A5);
    wait_done(33);

    // Reset mid-operation aborts without a done pulse
    issue(2'd3, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done_pending", 32'(exp_q.size()), 32'd0);

    issue(2'd1, 32'd2, 32'd3, 32'h0, 32'h00000006, 1'b0, 1'b1);
    wait_done(33);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
